// File: rtl/vpifo_req_scheduler.sv
// vpifo_req_scheduler: round-robin push arbiter and pop-credit scheduler with stall hysteresis for the vPIFO task generator
module vpifo_req_scheduler #(
  parameter int PTW           = 16,
  parameter int MTW           = 2,
  parameter int TREE_NUM      = 4,
  parameter int NUM_PORTS     = 4,
  parameter int CTW           = 10,
  parameter int MAX_OCC       = 1000,
  parameter int PCW           = 4,
  parameter int RESUME_CYCLES = 4,
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst_n,
  input  logic [NUM_PORTS-1:0]                 i_req_valid,
  input  logic [NUM_PORTS*TREE_NUM_BITS-1:0]   i_req_tree_id,
  input  logic [NUM_PORTS*PTW-1:0]             i_req_priority,
  input  logic [NUM_PORTS*(MTW+PTW)-1:0]       i_req_data,
  output logic [NUM_PORTS-1:0]                 o_req_ready,
  input  logic                                 i_pop_req,
  output logic                                 o_pop_req_ready,
  output logic                                 o_push,
  output logic [TREE_NUM_BITS-1:0]             o_push_tree_id,
  output logic [PTW-1:0]                       o_push_priority,
  output logic [MTW+PTW-1:0]                   o_push_data,
  output logic                                 o_pop,
  input  logic                                 i_task_fifo_full,
  input  logic                                 i_pop_out,
  output logic [CTW-1:0]                       o_occupancy,
  output logic [PCW-1:0]                       o_pop_pending,
  output logic [PCW-1:0]                       o_pop_outstanding,
  output logic                                 o_stalled
);
  localparam int DW = MTW + PTW;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int RW = $clog2(RESUME_CYCLES + 1);
  localparam logic [PCW-1:0] PMAX = {PCW{1'b1}};
  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_nx;
  logic [RW-1:0] res_cnt, res_cnt_nx;
  logic [PW-1:0] rr_ptr, idx, gidx;
  logic found, issue_ok, push_ok, pop_issue, pop_acc;
  assign issue_ok        = (state == RUN) && !i_task_fifo_full;
  assign push_ok         = issue_ok && (o_occupancy < CTW'(MAX_OCC));
  assign pop_issue       = issue_ok && |o_pop_pending && |o_occupancy && (o_pop_outstanding != PMAX);
  assign o_pop_req_ready = o_pop_pending != PMAX;
  assign pop_acc         = i_pop_req && o_pop_req_ready;
  assign o_stalled       = state == STALL;
  assign o_req_ready     = found ? NUM_PORTS'(1) << gidx : '0;
  always_comb begin
    state_nx   = state;
    res_cnt_nx = res_cnt;
    if (state == RUN) begin
      state_nx   = i_task_fifo_full ? STALL : RUN;
      res_cnt_nx = i_task_fifo_full ? '0 : res_cnt;
    end else if (i_task_fifo_full) begin
      res_cnt_nx = '0;
    end else if (res_cnt == RW'(RESUME_CYCLES - 1)) begin
      state_nx = RUN;
    end else begin
      res_cnt_nx = res_cnt + 1'b1;
    end
  end
  // first valid port at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (push_ok && !found && i_req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state             <= RUN;
      res_cnt           <= '0;
      rr_ptr            <= '0;
      o_push            <= 1'b0;
      o_push_tree_id    <= '0;
      o_push_priority   <= '0;
      o_push_data       <= '0;
      o_pop             <= 1'b0;
      o_occupancy       <= '0;
      o_pop_pending     <= '0;
      o_pop_outstanding <= '0;
    end else begin
      state             <= state_nx;
      res_cnt           <= res_cnt_nx;
      rr_ptr            <= found ? PW'((int'(gidx) + 1) % NUM_PORTS) : rr_ptr;
      o_push            <= found;
      o_pop             <= pop_issue;
      o_occupancy       <= o_occupancy + CTW'(found) - CTW'(pop_issue);
      o_pop_pending     <= o_pop_pending + PCW'(pop_acc) - PCW'(pop_issue);
      o_pop_outstanding <= o_pop_outstanding + PCW'(pop_issue) - PCW'(i_pop_out && |o_pop_outstanding);
      if (found) begin
        o_push_tree_id  <= i_req_tree_id[int'(gidx)*TREE_NUM_BITS +: TREE_NUM_BITS];
        o_push_priority <= i_req_priority[int'(gidx)*PTW +: PTW];
        o_push_data     <= i_req_data[int'(gidx)*DW +: DW];
      end
    end
  end
endmodule

// File: tb/tb_vpifo_req_scheduler.sv
// tb_vpifo_req_scheduler: scoreboard bench with a transaction-level reference model of the request scheduler
module tb_vpifo_req_scheduler;
  localparam int NP = 4, TBW = 2, PTW = 16, MTW = 2, DW = 18;
  localparam int MAXO = 20, PMAX = 15, RES = 4;
  logic i_clk = 0, i_arst_n = 0;
  logic [NP-1:0] i_req_valid = '0;
  logic [NP*TBW-1:0] i_req_tree_id = '0;
  logic [NP*PTW-1:0] i_req_priority = '0;
  logic [NP*DW-1:0] i_req_data = '0;
  logic i_pop_req = 0, i_task_fifo_full = 0, i_pop_out = 0;
  logic [NP-1:0] o_req_ready;
  logic o_pop_req_ready, o_push, o_pop, o_stalled;
  logic [TBW-1:0] o_push_tree_id;
  logic [PTW-1:0] o_push_priority;
  logic [DW-1:0] o_push_data;
  logic [9:0] o_occupancy;
  logic [3:0] o_pop_pending, o_pop_outstanding;
  always #5 i_clk = ~i_clk;
  vpifo_req_scheduler #(.PTW(PTW), .MTW(MTW), .TREE_NUM(4), .NUM_PORTS(NP), .CTW(10),
                        .MAX_OCC(MAXO), .PCW(4), .RESUME_CYCLES(RES)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_req_valid(i_req_valid), .i_req_tree_id(i_req_tree_id),
    .i_req_priority(i_req_priority), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .i_pop_req(i_pop_req), .o_pop_req_ready(o_pop_req_ready), .o_push(o_push),
    .o_push_tree_id(o_push_tree_id), .o_push_priority(o_push_priority), .o_push_data(o_push_data),
    .o_pop(o_pop), .i_task_fifo_full(i_task_fifo_full), .i_pop_out(i_pop_out),
    .o_occupancy(o_occupancy), .o_pop_pending(o_pop_pending), .o_pop_outstanding(o_pop_outstanding),
    .o_stalled(o_stalled));
  typedef struct {int cyc; logic [TBW-1:0] tree; logic [PTW-1:0] prio; logic [DW-1:0] data;} push_t;
  push_t push_q[$];
  int pop_q[$];
  push_t r;
  int checks = 0, errors = 0, cyc = 0, pops_seen = 0;
  int m_rr, m_occ, m_pend, m_out, m_quiet;
  bit m_stall;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_rr = 0; m_occ = 0; m_pend = 0; m_out = 0; m_quiet = 0; m_stall = 0;
    push_q.delete();
    pop_q.delete();
  endtask
  // one clock of stimulus; the model predicts what the next rising edge must produce
  task automatic step(input logic [NP-1:0] v, input bit full, input bit pr, input bit po);
    int g, out0;
    bit can, pop, acc;
    @(negedge i_clk);
    i_req_valid = v; i_task_fifo_full = full; i_pop_req = pr; i_pop_out = po;
    for (int p = 0; p < NP; p++) begin
      i_req_tree_id[p*TBW +: TBW] = TBW'($urandom);
      i_req_priority[p*PTW +: PTW] = PTW'($urandom);
      i_req_data[p*DW +: DW] = DW'($urandom);
    end
    #1;
    can = !m_stall && !full;
    g = -1;
    if (can && m_occ < MAXO)
      for (int k = 0; k < NP; k++)
        if (g < 0 && v[(m_rr + k) % NP]) g = (m_rr + k) % NP;
    pop = can && m_pend > 0 && m_occ > 0 && m_out != PMAX;
    acc = pr && m_pend != PMAX;
    out0 = m_out;
    chk("req_ready", o_req_ready, (g < 0) ? 0 : (1 << g));
    chk("pop_req_ready", o_pop_req_ready, m_pend != PMAX);
    if (g >= 0) begin
      push_q.push_back('{cyc + 1, i_req_tree_id[g*TBW +: TBW], i_req_priority[g*PTW +: PTW], i_req_data[g*DW +: DW]});
      m_rr = (g + 1) % NP;
      m_occ++;
    end
    if (pop) begin
      pop_q.push_back(cyc + 1);
      m_occ--; m_pend--; m_out++;
    end
    if (acc) m_pend++;
    if (po && out0 > 0) m_out--;
    if (full) begin
      m_stall = 1; m_quiet = 0;
    end else if (m_stall) begin
      m_quiet++;
      if (m_quiet == RES) m_stall = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge i_clk);
    i_arst_n = 0; i_req_valid = '0; i_pop_req = 0; i_pop_out = 0; i_task_fifo_full = 0;
    #1;
    chk("rst_push", o_push, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_pend", o_pop_pending, 0);
    chk("rst_outst", o_pop_outstanding, 0);
    chk("rst_stalled", o_stalled, 0);
    chk("rst_ready", o_req_ready, 0);
    chk("rst_tree", o_push_tree_id, 0);
    chk("rst_prio", o_push_priority, 0);
    chk("rst_data", o_push_data, 0);
    model_reset();
    @(negedge i_clk);
    i_arst_n = 1;
  endtask
  always @(posedge i_clk) begin
    #1;
    cyc++;
    if (o_push) begin
      if (push_q.size() == 0) chk("push_unexpected", 1, 0);
      else begin
        r = push_q.pop_front();
        chk("push_cycle", cyc, r.cyc);
        chk("push_tree", o_push_tree_id, r.tree);
        chk("push_prio", o_push_priority, r.prio);
        chk("push_data", o_push_data, r.data);
      end
    end else if (push_q.size() > 0 && push_q[0].cyc <= cyc) begin
      chk("push_missing", 0, 1);
      void'(push_q.pop_front());
    end
    if (o_pop) begin
      pops_seen++;
      if (pop_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("pop_cycle", cyc, pop_q.pop_front());
    end else if (pop_q.size() > 0 && pop_q[0] <= cyc) begin
      chk("pop_missing", 0, 1);
      void'(pop_q.pop_front());
    end
    chk("occupancy", o_occupancy, m_occ);
    chk("pending", o_pop_pending, m_pend);
    chk("outstanding", o_pop_outstanding, m_out);
    chk("stalled", o_stalled, m_stall);
  end
  initial begin
    int p0, seg;
    model_reset();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 0, 0, 0);
      chk("rr_order", o_req_ready, 1 << (k % 4));
    end
    @(posedge i_clk); #2;
    chk("occ_after_8", o_occupancy, 8);
    step(4'b0100, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    chk("rr3_port2", o_req_ready, 4'b0100);
    step(4'b1001, 0, 0, 0);
    chk("rr3_port3_first", o_req_ready, 4'b1000);
    do_reset();
    for (int k = 0; k < 3; k++) step(4'h0, 0, 1, 0);
    @(posedge i_clk); #2;
    chk("pend_3", o_pop_pending, 3);
    p0 = pops_seen;
    step(4'b0001, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(4'h0, 0, 0, 0);
    @(posedge i_clk); #2;
    chk("pend_2", o_pop_pending, 2);
    chk("occ_drained", o_occupancy, 0);
    chk("one_pop", pops_seen - p0, 1);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1, 0, 0);
      if (k == 0) begin
        @(posedge i_clk); #2;
        chk("stall_enter", o_stalled, 1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 0, 0, 0);
      chk("resume", |o_req_ready, k == 4);
    end
    step(4'hF, 1, 0, 0);
    step(4'hF, 0, 0, 0);
    step(4'hF, 0, 0, 0);
    step(4'hF, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 0, 0, 0);
      chk("resume_glitch", |o_req_ready, k == 4);
    end
    do_reset();
    for (int k = 0; k < MAXO; k++) step(4'hF, 0, 0, 0);
    step(4'hF, 0, 1, 0);
    chk("max_block", o_req_ready, 0);
    step(4'hF, 0, 0, 0);
    chk("max_block_pop", o_req_ready, 0);
    @(posedge i_clk); #2;
    chk("max_pop", o_pop, 1);
    chk("max_occ_dec", o_occupancy, MAXO - 1);
    step(4'hF, 0, 0, 0);
    chk("max_regrant", |o_req_ready, 1);
    for (int i = 0; i < 3200; i++) begin
      seg = (i / 200) % 4;
      if (i % 800 == 799) do_reset();
      else step((seg == 1) ? NP'($urandom_range(0, 1) ? 0 : $urandom) : NP'($urandom),
                $urandom_range(0, 19) == 0,
                (seg == 2) ? 1'b1 : ($urandom_range(0, 2) == 0),
                (seg == 3) ? ($urandom_range(0, 15) == 0) : ((m_out > 0) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 9) == 0));
    end
    do_reset();
    step(4'h0, 0, 0, 1);
    @(posedge i_clk); #2;
    chk("pop_out_ignored", o_pop_outstanding, 0);
    for (int k = 0; k < 40; k++) step(4'h0, 0, 0, 1);
    chk("push_q_empty", push_q.size(), 0);
    chk("pop_q_empty", pop_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
